product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Downstream consumer of the registered 8x8 signed Booth multiplier.
- Accepts a stream of 16-bit signed products over a valid/ready handshake and sums a programmed number of them (vector length) into a saturating signed accumulator.
- Presents the dot-product result on an output valid/ready handshake with a sticky overflow flag.
- Sits between the multiplier's product port and the result sink of the MAC datapath.

Parameters:
- PROD_W, 16, width of signed product input (matches the 8x8 multiplier output)
- ACC_W, 20, width of signed accumulator/result; must be >= PROD_W
- LEN_W, 8, width of vector-length field

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a new accumulation (honoured in IDLE only)
- vec_len  input  LEN_W  number of products to accumulate; sampled when start is honoured
- prod_valid  input  1  product is valid this cycle
- product  input  PROD_W  signed product from the multiplier
- prod_ready  output  1  block will accept product this cycle
- acc_valid  output  1  acc_out holds a final result
- acc_out  output  ACC_W  signed accumulated result
- acc_ready  input  1  sink accepts result
- overflow  output  1  saturation occurred during this accumulation
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, prod_ready=0, acc_valid=0, acc_out=0, overflow=0, busy=0, internal count=0. Reset asserted mid-operation aborts immediately; any in-flight or held result is discarded.
- States: IDLE, ACCUM, HOLD.
- IDLE, start=1, vec_len!=0:
  - latch count=vec_len, clear acc_out=0 and overflow=0
  - next state ACCUM
- IDLE, start=1, vec_len=0:
  - clear acc_out and overflow
  - next state HOLD; acc_valid=1 on the following cycle with result 0
- IDLE, start=0: stay. start in ACCUM or HOLD is ignored.
- ACCUM:
  - prod_ready=1 (registered, asserted from the first ACCUM cycle)
  - a transfer occurs when prod_valid and prod_ready are both high
  - on each transfer: acc_out <= sat(acc_out + sign_ext(product)); count decrements
  - prod_valid=0 cycles are stalls: no state change
- Arithmetic:
  - sum is computed at ACC_W+1 bits
  - saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; for ACC_W=20 that is [-524288, 524287]
  - any saturation sets overflow (sticky until the next honoured start or reset)
  - after saturating, the accumulator continues from the clamped value; no wrap-around ever
- Last transfer (count==1):
  - next state HOLD; prod_ready drops the cycle after that transfer, so no extra product is accepted
  - acc_valid=1 the cycle after the last transfer (1-cycle result latency)
- HOLD:
  - acc_valid=1; acc_out and overflow held stable; prod_ready=0
  - acc_valid & acc_ready -> IDLE next cycle, acc_valid=0
  - acc_out and overflow retain their values in IDLE until the next start
  - acc_ready may be held low indefinitely; outputs must not change while held
- Back-to-back: start in the first IDLE cycle after a HOLD handoff is honoured (2-cycle minimum gap between results).
- busy = (state != IDLE).

Test Plan:
- vec_len=3, products -405, 100, -100 with prod_valid continuous -> acc_valid one cycle after third transfer, acc_out=-405 (0xFFE6B), overflow=0, exactly 3 transfers observed.
- vec_len=32, product=16384 each (-128*-128) -> first 31 sums exact (507904); 32nd saturates, acc_out=524287 (0x7FFFF), overflow=1.
- vec_len=33, product=-16256 each (-128*127) -> acc_out=-524288 (0x80000), overflow=1; next start with vec_len=1, product=10 -> acc_out=10, overflow=0.
- vec_len=4, products 100 each, prod_valid toggling 1,0,0,1,1,0,1; then acc_ready held low 3 cycles -> acc_out=400; acc_valid and acc_out stable for all 3 held cycles; IDLE one cycle after acc_ready=1; start pulses during ACCUM and HOLD ignored.
- vec_len=0 with start -> acc_valid=1 next cycle, acc_out=0, prod_ready never asserted.
- Assert rst_n=0 after 2 of 5 transfers -> all outputs 0 immediately (asynchronously); after release, a new start with vec_len=2, products 7 and -3 -> acc_out=4.

Source files
------------

// File: rtl/product_accumulator.sv
// Saturating dot-product accumulator: sums vec_len signed products taken over a
// valid/ready handshake and holds the result on an output valid/ready handshake.
module product_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 20,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] product,
    output logic              prod_ready,
    output logic              acc_valid,
    output logic [ACC_W-1:0]  acc_out,
    input  logic              acc_ready,
    output logic              overflow,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

    // Returns {saturated, clamped_sum}; the sum is formed one bit wider so a
    // sign mismatch between the top two bits exposes the overflow direction.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0]  acc,
                                               input logic [PROD_W-1:0] prod);
        logic [ACC_W:0] sum;
        sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            sat_add = {1'b1, (sum[ACC_W] ? ACC_MIN : ACC_MAX)};
        end else begin
            sat_add = {1'b0, sum[ACC_W-1:0]};
        end
    endfunction

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             prod_ready_q, prod_ready_d;
    logic             acc_valid_q, acc_valid_d;
    logic             busy_q, busy_d;
    logic             xfer_s;
    logic [ACC_W:0]   sat_sum_s;

    assign xfer_s    = (state_q == S_ACCUM) && prod_valid && prod_ready_q;
    assign sat_sum_s = sat_add(acc_q, product);

    // Next-state and datapath update for the IDLE/ACCUM/HOLD sequence.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        acc_d        = acc_q;
        ovf_d        = ovf_q;
        prod_ready_d = prod_ready_q;
        acc_valid_d  = acc_valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d = {ACC_W{1'b0}};
                    ovf_d = 1'b0;
                    if (vec_len != LEN_ZERO) begin
                        state_d      = S_ACCUM;
                        count_d      = vec_len;
                        prod_ready_d = 1'b1;
                    end else begin
                        state_d     = S_HOLD;
                        acc_valid_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (xfer_s) begin
                    acc_d   = sat_sum_s[ACC_W-1:0];
                    ovf_d   = ovf_q | sat_sum_s[ACC_W];
                    count_d = count_q - LEN_ONE;
                    // Dropping ready here guarantees no product past the last one.
                    if (count_q == LEN_ONE) begin
                        state_d      = S_HOLD;
                        prod_ready_d = 1'b0;
                        acc_valid_d  = 1'b1;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_HOLD: begin
                if (acc_ready) begin
                    state_d     = S_IDLE;
                    acc_valid_d = 1'b0;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d      = S_IDLE;
                prod_ready_d = 1'b0;
                acc_valid_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset discards any in-flight or held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            count_q      <= {LEN_W{1'b0}};
            acc_q        <= {ACC_W{1'b0}};
            ovf_q        <= 1'b0;
            prod_ready_q <= 1'b0;
            acc_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
            prod_ready_q <= prod_ready_d;
            acc_valid_q  <= acc_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign prod_ready = prod_ready_q;
    assign acc_valid  = acc_valid_q;
    assign acc_out    = acc_q;
    assign overflow   = ovf_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: inputs driven and outputs sampled on
// the falling clock edge, expected values hand-computed.
module tb_product_accumulator;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [7:0]         vec_len;
    logic               prod_valid;
    logic signed [15:0] product;
    logic               prod_ready;
    logic               acc_valid;
    logic [19:0]        acc_out;
    logic               acc_ready;
    logic               overflow;
    logic               busy;

    int total = 0;
    int bad   = 0;

    logic signed [15:0] pv [0:63];
    logic               vp [0:63];
    int                 plen;
    bit                 use_pat;
    int                 xfers;
    bit                 timed_out;
    bit                 early_valid;

    product_accumulator #(.PROD_W(16), .ACC_W(20), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
        .prod_valid(prod_valid), .product(product), .prod_ready(prod_ready),
        .acc_valid(acc_valid), .acc_out(acc_out), .acc_ready(acc_ready),
        .overflow(overflow), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulses start at a falling edge; returns at the next falling edge.
    task automatic do_start(input logic [7:0] len);
        start   = 1'b1;
        vec_len = len;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Offers pv[0..plen-1] (optionally gated by vp) until all are transferred.
    task automatic drive_stream();
        int idx = 0;
        int cyc = 0;
        xfers = 0;
        early_valid = 1'b0;
        while (idx < plen && cyc < 200) begin
            prod_valid = use_pat ? vp[cyc] : 1'b1;
            product    = pv[idx];
            if (acc_valid) early_valid = 1'b1;
            if (prod_valid && prod_ready) begin
                xfers++;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        prod_valid = 1'b0;
        timed_out  = (idx < plen);
    endtask

    task automatic release_result();
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; vec_len = 8'd0; prod_valid = 1'b0;
        product = 16'sd0; acc_ready = 1'b0; use_pat = 1'b0;
        repeat (2) @(negedge clk);
        total++; if ({prod_ready, acc_valid, overflow, busy} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {prod_ready, acc_valid, overflow, busy}); end
        total++; if (acc_out !== 20'h00000) begin bad++; $display("FAIL reset_acc got=%h want=00000", acc_out); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if ({prod_ready, acc_valid, busy} !== 3'b000) begin bad++; $display("FAIL idle_after_reset got=%b want=000", {prod_ready, acc_valid, busy}); end
    endtask

    task automatic test_basic();
        int extra = 0;
        do_start(8'd3);
        total++; if ({prod_ready, busy} !== 2'b11) begin bad++; $display("FAIL basic_ready got=%b want=11", {prod_ready, busy}); end
        pv[0] = -16'sd405; pv[1] = 16'sd100; pv[2] = -16'sd100; plen = 3;
        drive_stream();
        total++; if (timed_out) begin bad++; $display("FAIL basic_timeout got=%0d want=3 transfers", xfers); end
        total++; if (early_valid) begin bad++; $display("FAIL basic_early_valid got=1 want=0"); end
        total++; if ({acc_valid, prod_ready} !== 2'b10) begin bad++; $display("FAIL basic_valid got=%b want=10", {acc_valid, prod_ready}); end
        total++; if (acc_out !== 20'hFFE6B || overflow !== 1'b0) begin bad++; $display("FAIL basic_result got=%h/%b want=FFE6B/0", acc_out, overflow); end
        prod_valid = 1'b1; product = 16'sd1;
        repeat (2) begin
            if (prod_ready) extra++;
            @(negedge clk);
        end
        prod_valid = 1'b0;
        total++; if (xfers + extra !== 3) begin bad++; $display("FAIL basic_xfer_count got=%0d want=3", xfers + extra); end
        total++; if (acc_out !== 20'hFFE6B) begin bad++; $display("FAIL basic_held got=%h want=FFE6B", acc_out); end
        release_result();
        total++; if ({acc_valid, busy} !== 2'b00) begin bad++; $display("FAIL basic_idle got=%b want=00", {acc_valid, busy}); end
    endtask

    task automatic test_pos_sat();
        do_start(8'd32);
        for (int i = 0; i < 31; i++) pv[i] = 16'sd16384;
        plen = 31;
        drive_stream();
        total++; if (timed_out || acc_out !== 20'h7C000 || overflow !== 1'b0 || acc_valid !== 1'b0) begin bad++; $display("FAIL pos_31_sum got=%h/%b/%b want=7C000/0/0", acc_out, overflow, acc_valid); end
        plen = 1;
        drive_stream();
        total++; if (timed_out || acc_valid !== 1'b1) begin bad++; $display("FAIL pos_valid got=%b want=1", acc_valid); end
        total++; if (acc_out !== 20'h7FFFF || overflow !== 1'b1) begin bad++; $display("FAIL pos_sat got=%h/%b want=7FFFF/1", acc_out, overflow); end
        release_result();
    endtask

    task automatic test_neg_sat_back_to_back();
        do_start(8'd33);
        for (int i = 0; i < 33; i++) pv[i] = -16'sd16256;
        plen = 32;
        drive_stream();
        total++; if (timed_out || acc_out !== 20'h81000 || overflow !== 1'b0) begin bad++; $display("FAIL neg_32_sum got=%h/%b want=81000/0", acc_out, overflow); end
        plen = 1;
        drive_stream();
        total++; if (acc_valid !== 1'b1 || acc_out !== 20'h80000 || overflow !== 1'b1) begin bad++; $display("FAIL neg_sat got=%b/%h/%b want=1/80000/1", acc_valid, acc_out, overflow); end
        release_result();
        do_start(8'd1);
        total++; if (overflow !== 1'b0 || acc_out !== 20'h00000 || prod_ready !== 1'b1) begin bad++; $display("FAIL b2b_clear got=%b/%h/%b want=0/00000/1", overflow, acc_out, prod_ready); end
        pv[0] = 16'sd10; plen = 1;
        drive_stream();
        total++; if (timed_out || acc_valid !== 1'b1 || acc_out !== 20'h0000A || overflow !== 1'b0) begin bad++; $display("FAIL b2b_result got=%b/%h/%b want=1/0000A/0", acc_valid, acc_out, overflow); end
        release_result();
    endtask

    task automatic test_stall_hold();
        bit held_ok = 1'b1;
        do_start(8'd4);
        start = 1'b1; vec_len = 8'd50;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) pv[i] = 16'sd100;
        vp[0] = 1'b1; vp[1] = 1'b0; vp[2] = 1'b0; vp[3] = 1'b1;
        vp[4] = 1'b1; vp[5] = 1'b0; vp[6] = 1'b1;
        use_pat = 1'b1; plen = 4;
        drive_stream();
        use_pat = 1'b0;
        total++; if (timed_out || early_valid) begin bad++; $display("FAIL stall_stream got=%0d xfers want=4", xfers); end
        total++; if (acc_valid !== 1'b1 || acc_out !== 20'd400) begin bad++; $display("FAIL stall_result got=%b/%0d want=1/400", acc_valid, acc_out); end
        for (int i = 0; i < 3; i++) begin
            start = (i == 1); vec_len = 8'd7;
            @(negedge clk);
            if (acc_valid !== 1'b1 || acc_out !== 20'd400 || overflow !== 1'b0 || prod_ready !== 1'b0) held_ok = 1'b0;
        end
        start = 1'b0;
        total++; if (!held_ok) begin bad++; $display("FAIL hold_stable got=%b/%0d want=1/400", acc_valid, acc_out); end
        release_result();
        total++; if ({acc_valid, busy} !== 2'b00 || acc_out !== 20'd400) begin bad++; $display("FAIL hold_to_idle got=%b/%0d want=00/400", {acc_valid, busy}, acc_out); end
    endtask

    task automatic test_zero_len();
        bit ready_seen = 1'b0;
        do_start(8'd0);
        if (prod_ready) ready_seen = 1'b1;
        total++; if ({acc_valid, busy} !== 2'b11 || acc_out !== 20'h00000 || overflow !== 1'b0) begin bad++; $display("FAIL zero_result got=%b/%h want=11/00000", {acc_valid, busy}, acc_out); end
        release_result();
        if (prod_ready) ready_seen = 1'b1;
        total++; if (ready_seen || acc_valid !== 1'b0) begin bad++; $display("FAIL zero_ready got=%b/%b want=0/0", ready_seen, acc_valid); end
    endtask

    task automatic test_async_reset();
        do_start(8'd5);
        pv[0] = 16'sd1000; pv[1] = 16'sd2000; plen = 2;
        drive_stream();
        total++; if (acc_out !== 20'd3000 || prod_ready !== 1'b1) begin bad++; $display("FAIL mid_sum got=%0d/%b want=3000/1", acc_out, prod_ready); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({prod_ready, acc_valid, overflow, busy} !== 4'b0000 || acc_out !== 20'h00000) begin bad++; $display("FAIL async_reset got=%b/%h want=0000/00000", {prod_ready, acc_valid, overflow, busy}, acc_out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(8'd2);
        pv[0] = 16'sd7; pv[1] = -16'sd3; plen = 2;
        drive_stream();
        total++; if (timed_out || acc_valid !== 1'b1 || acc_out !== 20'd4) begin bad++; $display("FAIL post_reset got=%b/%0d want=1/4", acc_valid, acc_out); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pos_sat();
        test_neg_sat_back_to_back();
        test_stall_hold();
        test_zero_len();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
